// File: rtl/cpu_run_controller_pkg.sv
// cpu_run_pkg: shared types and helpers for the Hack CPU run controller.
//
// Contents:
//   run_state_t     - controller FSM state encoding (also exported as a
//                     debug output of the top level)
//   HALT_REPS_DEF   - default number of loop detections that declare halt
//   MAX_CYCLES_DEF  - default RUN-cycle budget before timeout
//   is_a_instr()    - true for a Hack A-instruction (bit 15 clear)
package cpu_run_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RST  = 3'd1,
        ST_RUN  = 3'd2,
        ST_DONE = 3'd3,
        ST_TOUT = 3'd4
    } run_state_t;

    localparam int HALT_REPS_DEF  = 3;
    localparam int MAX_CYCLES_DEF = 3276800;

    // A Hack A-instruction ("@value") has bit 15 clear; every C-instruction
    // has it set.
    function automatic logic is_a_instr(input logic [15:0] word);
        return ~word[15];
    endfunction

endpackage

// File: rtl/cpu_run_controller_if.sv
// cpu_run_controller_if: bus bundle between the run controller and its
// surroundings (CPU core, instruction ROM, data RAM and host RAM port).
//
// Signal groups:
//   CPU  : cpu_reset, cpu_pc, cpu_instr, cpu_addrM, cpu_outM, cpu_writeM,
//          cpu_inM
//   ROM  : rom_addr (to ROM), rom_data (asynchronous read word)
//   RAM  : ram_addr, ram_wdata, ram_we (to RAM), ram_rdata (async read)
//   Host : host_addr, host_wdata, host_we (from host), host_gnt,
//          host_rdata (to host)
//
// Modports:
//   master - the run controller
//   slave  - the environment (CPU, memories, host)
//
// Host handshake: host_we is the host's valid and host_gnt is the
// controller's ready. A host write lands on the rising clk edge at which
// host_we and host_gnt are both high; with host_gnt low the write is
// dropped, never queued. host_gnt depends on controller state only, so the
// host may look at it and drive host_we in the same cycle. host_rdata is
// meaningful whenever host_gnt is high.
interface cpu_run_controller_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);

    logic              cpu_reset;
    logic [15:0]       cpu_pc;
    logic [15:0]       cpu_instr;
    logic [15:0]       cpu_addrM;
    logic [15:0]       cpu_outM;
    logic              cpu_writeM;
    logic [15:0]       cpu_inM;

    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_we;
    logic              host_gnt;
    logic [DATA_W-1:0] host_rdata;

    modport master (
        output cpu_reset, cpu_instr, cpu_inM,
        output rom_addr,
        output ram_addr, ram_wdata, ram_we,
        output host_gnt, host_rdata,
        input  cpu_pc, cpu_addrM, cpu_outM, cpu_writeM,
        input  rom_data, ram_rdata,
        input  host_addr, host_wdata, host_we
    );

    modport slave (
        input  cpu_reset, cpu_instr, cpu_inM,
        input  rom_addr,
        input  ram_addr, ram_wdata, ram_we,
        input  host_gnt, host_rdata,
        output cpu_pc, cpu_addrM, cpu_outM, cpu_writeM,
        output rom_data, ram_rdata,
        output host_addr, host_wdata, host_we
    );

endinterface

// File: rtl/cpu_run_controller_halt_detector.sv
// halt_detector: recognises the Hack end-of-program idiom
//     (END) @END
//           0;JMP
// which makes the PC alternate END, END+1, END, ...
//
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   clear      - synchronous clear of history and count (held during RST)
//   run        - high on cycles where the CPU executes an instruction
//   pc         - current CPU program counter
//   instr      - ROM word at pc
//   halt       - combinational: this RUN edge carries the HALT_REPS-th event
module halt_detector
    import cpu_run_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int HALT_REPS = HALT_REPS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              run,
    input  logic [15:0]       pc,
    input  logic [DATA_W-1:0] instr,
    output logic              halt
);

    localparam int CNT_W = $clog2(HALT_REPS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HALT_REPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALT_REPS - 1);

    logic [15:0]      pc1;
    logic [15:0]      pc2;
    logic [1:0]       hist;
    logic [CNT_W-1:0] count;
    logic             loop_event;

    // The instruction must load its own address and the PC must have come
    // back to where it was two instructions ago. Both history slots have to
    // hold real RUN-cycle PCs, otherwise the stale zeroes after a clear
    // would match the instruction at address 0.
    always_comb begin
        loop_event = run
                  && (hist == 2'b11)
                  && is_a_instr(instr[15:0])
                  && (instr[14:0] == pc[14:0])
                  && (pc == pc2);
        halt = loop_event && (count == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            pc1   <= '0;
            pc2   <= '0;
            hist  <= '0;
            count <= '0;
        end else if (run) begin
            pc2  <= pc1;
            pc1  <= pc;
            hist <= {hist[0], 1'b1};
            if (loop_event && (count != CNT_MAX)) begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: run sequencer and data-RAM arbiter for a Hack CPU.
//
// The CPU is held in reset until the host pulses start. One RST cycle
// later the CPU runs until either the end-of-program self loop has been
// seen HALT_REPS times (DONE) or MAX_CYCLES RUN cycles have elapsed (TOUT).
// Outside RST/RUN the host owns the single RAM port.
//
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   start      - one-cycle pulse, honoured in IDLE, DONE and TOUT only
//   busy       - high in RST and RUN
//   done       - high in DONE
//   timeout    - high in TOUT
//   cycles     - RUN cycles since the last accepted start (saturating)
//   dbg_state  - current FSM state
//   bus        - CPU / ROM / RAM / host bundle (master side)
module cpu_run_controller
    import cpu_run_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 16,
    parameter int MAX_CYCLES = MAX_CYCLES_DEF,
    parameter int HALT_REPS  = HALT_REPS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [31:0]          cycles,
    output run_state_t           dbg_state,
    cpu_run_controller_if.master bus
);

    localparam logic [31:0] CYCLE_LAST = 32'(MAX_CYCLES - 1);

    run_state_t state;
    run_state_t next_state;
    logic       start_accept;
    logic       run;
    logic       halt;
    logic       at_limit;
    logic       host_gnt;
    logic       cpu_hold;
    logic       ram_we_raw;
    logic       unused_addr_bits;

    assign run       = (state == ST_RUN);
    assign at_limit  = (cycles == CYCLE_LAST);
    assign dbg_state = state;

    // Upper CPU address bits beyond the RAM window are not decoded.
    assign unused_addr_bits = ^bus.cpu_addrM;

    // ------------------------------------------------------------------
    // Halt detection; history and count are wiped while in RST so every
    // run starts from a clean slate.
    // ------------------------------------------------------------------
    halt_detector #(
        .DATA_W    (DATA_W),
        .HALT_REPS (HALT_REPS)
    ) u_halt (
        .clk   (clk),
        .reset (reset),
        .clear (state == ST_RST),
        .run   (run),
        .pc    (bus.cpu_pc),
        .instr (bus.rom_data),
        .halt  (halt)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. Halt wins over timeout on the same edge.
    // ------------------------------------------------------------------
    always_comb begin
        next_state   = state;
        start_accept = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE, ST_TOUT: begin
                if (start) begin
                    next_state   = ST_RST;
                    start_accept = 1'b1;
                end
            end
            ST_RST: begin
                next_state = ST_RUN;
            end
            ST_RUN: begin
                if (halt) begin
                    next_state = ST_DONE;
                end else if (at_limit) begin
                    next_state = ST_TOUT;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        timeout  = 1'b0;
        cpu_hold = 1'b1;
        host_gnt = 1'b0;
        unique case (state)
            ST_IDLE: begin
                host_gnt = 1'b1;
            end
            ST_RST: begin
                busy = 1'b1;
            end
            ST_RUN: begin
                busy     = 1'b1;
                cpu_hold = 1'b0;
            end
            ST_DONE: begin
                done     = 1'b1;
                host_gnt = 1'b1;
            end
            ST_TOUT: begin
                timeout  = 1'b1;
                host_gnt = 1'b1;
            end
            default: begin
                host_gnt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RUN cycle counter: cleared on the edge that accepts start,
    // saturating at all-ones.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cycles <= '0;
        end else if (start_accept) begin
            cycles <= '0;
        end else if (run && (cycles != '1)) begin
            cycles <= cycles + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // CPU and ROM path. The CPU is also held while the controller itself
    // is being reset so it cannot advance on that edge.
    // ------------------------------------------------------------------
    always_comb begin
        bus.cpu_reset = cpu_hold | reset;
        bus.rom_addr  = bus.cpu_pc[ADDR_W-1:0];
        bus.cpu_instr = run ? bus.rom_data : '0;
        bus.cpu_inM   = bus.ram_rdata;
    end

    // ------------------------------------------------------------------
    // RAM arbiter. The write strobe is suppressed during controller reset
    // so a reset that lands mid-store leaves memory untouched.
    // ------------------------------------------------------------------
    always_comb begin
        if (host_gnt) begin
            bus.ram_addr  = bus.host_addr;
            bus.ram_wdata = bus.host_wdata;
            ram_we_raw    = bus.host_we;
        end else begin
            bus.ram_addr  = bus.cpu_addrM[ADDR_W-1:0];
            bus.ram_wdata = bus.cpu_outM;
            ram_we_raw    = bus.cpu_writeM & run;
        end
        bus.ram_we     = ram_we_raw & ~reset;
        bus.host_gnt   = host_gnt;
        bus.host_rdata = bus.ram_rdata;
    end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: a behavioural Hack CPU, ROM and RAM sit
// around the controller; programs are loaded with random padding and
// random operands and results are predicted from plain arithmetic.
module tb_cpu_run_controller;
    import cpu_run_pkg::*;

    localparam int MAXC = 100;
    localparam int REPS = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [31:0] cycles;
    run_state_t  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    cpu_run_controller_if #(.ADDR_W(15), .DATA_W(16)) bus ();

    cpu_run_controller #(
        .ADDR_W     (15),
        .DATA_W     (16),
        .MAX_CYCLES (MAXC),
        .HALT_REPS  (REPS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .cycles    (cycles),
        .dbg_state (dbg_state),
        .bus       (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memories ----------------
    logic [15:0] rom [0:127];
    logic [15:0] ram [0:63];

    assign bus.rom_data  = (bus.rom_addr < 15'd128) ? rom[bus.rom_addr[6:0]] : 16'hEA87;
    assign bus.ram_rdata = ram[bus.ram_addr[5:0]];

    always @(posedge clk) begin
        if (bus.ram_we) ram[bus.ram_addr[5:0]] <= bus.ram_wdata;
    end

    // ---------------- behavioural Hack CPU ----------------
    logic [15:0] a_reg, d_reg, pc_reg;
    logic [15:0] alu_x, alu_y, alu_o;
    logic [15:0] ins;
    logic        is_c, jump;

    always_comb begin
        ins   = bus.cpu_instr;
        is_c  = ins[15];
        alu_x = d_reg;
        alu_y = ins[12] ? bus.cpu_inM : a_reg;
        if (ins[11]) alu_x = 16'h0;
        if (ins[10]) alu_x = ~alu_x;
        if (ins[9])  alu_y = 16'h0;
        if (ins[8])  alu_y = ~alu_y;
        alu_o = ins[7] ? (alu_x + alu_y) : (alu_x & alu_y);
        if (ins[6])  alu_o = ~alu_o;
        jump  = is_c && ((ins[2] && alu_o[15]) || (ins[1] && alu_o == 16'h0) ||
                         (ins[0] && !alu_o[15] && alu_o != 16'h0));
    end

    assign bus.cpu_pc     = pc_reg;
    assign bus.cpu_addrM  = a_reg;
    assign bus.cpu_outM   = alu_o;
    assign bus.cpu_writeM = is_c & ins[3];

    always @(posedge clk) begin
        if (bus.cpu_reset) begin
            pc_reg <= 16'h0;
            a_reg  <= 16'h0;
            d_reg  <= 16'h0;
        end else begin
            if (!is_c) a_reg <= ins;
            else if (ins[5]) a_reg <= alu_o;
            if (is_c && ins[4]) d_reg <= alu_o;
            pc_reg <= jump ? a_reg : pc_reg + 16'h1;
        end
    end

    // ---------------- programs and model ----------------
    // kind 0: RAM[2] = RAM[0] + RAM[1]
    // kind 1: additionally RAM[3] = RAM[0] - RAM[1]
    function automatic int end_offset(input int kind);
        return (kind == 0) ? 6 : 12;
    endfunction

    function automatic logic [15:0] prog_word(input int j, input int kind, input int end_addr);
        if (j == end_offset(kind)) return 16'(end_addr);
        if (j == end_offset(kind) + 1) return 16'hEA87;  // 0;JMP
        case (j)
            0, 6:    return 16'h0000;  // @0
            1, 7:    return 16'hFC10;  // D=M
            2, 8:    return 16'h0001;  // @1
            3:       return 16'hF090;  // D=D+M
            9:       return 16'hF4D0;  // D=D-M
            4:       return 16'h0002;  // @2
            10:      return 16'h0003;  // @3
            5, 11:   return 16'hE308;  // M=D
            default: return 16'hEA87;
        endcase
    endfunction

    // PC trace ends ..., END, END+1, END, END+1, ...; END is first reached at
    // RUN edge END+1 and the loop is recognised on every later visit, so the
    // halt edge is END+1 plus REPS round trips of two instructions.
    function automatic int exp_runs(input int end_addr);
        return end_addr + 1 + 2 * REPS;
    endfunction

    task automatic load_program(input int pad, input int kind);
        int end_addr;
        end_addr = pad + end_offset(kind);
        for (int i = 0; i < pad; i++) rom[i] = 16'h0000;
        for (int j = 0; j <= end_offset(kind) + 1; j++) rom[pad + j] = prog_word(j, kind, end_addr);
    endtask

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int addr, input logic [15:0] data);
        bus.host_addr  = 15'(addr);
        bus.host_wdata = data;
        bus.host_we    = 1'b1;
        step();
        bus.host_we    = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
    endtask

    // Steps RUN edges until done/timeout; runs counts RUN edges in total.
    task automatic run_to_end(input int r0, output int runs);
        runs = r0;
        for (int k = 0; k < 400; k++) begin
            if (done || timeout) break;
            step();
            runs++;
        end
        n_cmp++;
        if (!(done || timeout)) begin
            n_err++;
            $display("FAIL run_bound: got no done/timeout after %0d runs, required end of run", runs);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #1;
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_cmp++; if (done !== 1'b0 || timeout !== 1'b0) begin n_err++; $display("FAIL reset_flags: got done=%b timeout=%b required 0/0", done, timeout); end
        n_cmp++; if (cycles !== 32'd0) begin n_err++; $display("FAIL reset_cycles: got %0d required 0", cycles); end
        n_cmp++; if (bus.cpu_reset !== 1'b1 || bus.host_gnt !== 1'b1) begin n_err++; $display("FAIL reset_ctl: got cpu_reset=%b host_gnt=%b required 1/1", bus.cpu_reset, bus.host_gnt); end
    endtask

    task automatic test_host_access();
        for (int i = 0; i < 4; i++) begin
            int          addr;
            logic [15:0] data;
            addr = $urandom_range(8, 63);
            data = 16'($urandom);
            host_write(addr, data);
            n_cmp++; if (ram[addr] !== data) begin n_err++; $display("FAIL host_write: got %h required %h", ram[addr], data); end
            bus.host_addr = 15'(addr);
            #1;
            n_cmp++; if (bus.host_rdata !== data) begin n_err++; $display("FAIL host_read: got %h required %h", bus.host_rdata, data); end
        end
    endtask

    task automatic test_program(input int iters);
        for (int it = 0; it < iters; it++) begin
            int          pad, kind, runs, end_addr;
            logic [15:0] a, b, e_sum, e_dif;
            pad  = $urandom_range(0, 20);
            kind = $urandom_range(0, 1);
            a    = 16'($urandom);
            b    = 16'($urandom);
            if (it == 0) begin a = 16'd42; b = 16'd7; kind = 1; end
            if (it == 1) begin a = 16'hFFF9; b = 16'd2; end
            end_addr = pad + end_offset(kind);
            e_sum = a + b;
            e_dif = (kind == 1) ? a - b : 16'hBEEF;
            load_program(pad, kind);
            host_write(2, 16'hDEAD);
            host_write(3, 16'hBEEF);
            host_write(0, a);
            host_write(1, b);
            pulse_start();
            n_cmp++; if (dbg_state !== ST_RST || busy !== 1'b1 || bus.host_gnt !== 1'b0 || bus.cpu_reset !== 1'b1)
                begin n_err++; $display("FAIL prog_rst: got st=%0d busy=%b gnt=%b cpu_reset=%b required RST/1/0/1", dbg_state, busy, bus.host_gnt, bus.cpu_reset); end
            n_cmp++; if (cycles !== 32'd0) begin n_err++; $display("FAIL prog_clear: got %0d required 0", cycles); end
            step();
            n_cmp++; if (dbg_state !== ST_RUN || bus.cpu_reset !== 1'b0) begin n_err++; $display("FAIL prog_run: got st=%0d cpu_reset=%b required RUN/0", dbg_state, bus.cpu_reset); end
            run_to_end(0, runs);
            n_cmp++; if (runs != exp_runs(end_addr)) begin n_err++; $display("FAIL prog_runs: got %0d required %0d", runs, exp_runs(end_addr)); end
            n_cmp++; if (cycles !== 32'(exp_runs(end_addr))) begin n_err++; $display("FAIL prog_cycles: got %0d required %0d", cycles, exp_runs(end_addr)); end
            n_cmp++; if (done !== 1'b1 || timeout !== 1'b0 || busy !== 1'b0 || bus.host_gnt !== 1'b1)
                begin n_err++; $display("FAIL prog_flags: got done=%b tout=%b busy=%b gnt=%b required 1/0/0/1", done, timeout, busy, bus.host_gnt); end
            n_cmp++; if (ram[2] !== e_sum) begin n_err++; $display("FAIL prog_sum: got %h required %h", ram[2], e_sum); end
            n_cmp++; if (ram[3] !== e_dif) begin n_err++; $display("FAIL prog_dif: got %h required %h", ram[3], e_dif); end
            bus.host_addr = 15'd2;
            #1;
            n_cmp++; if (bus.host_rdata !== e_sum) begin n_err++; $display("FAIL prog_readback: got %h required %h", bus.host_rdata, e_sum); end
        end
    endtask

    task automatic test_start_during_run();
        int runs;
        load_program(0, 1);
        host_write(0, 16'd100);
        host_write(1, 16'd30);
        pulse_start();
        step();
        for (int k = 0; k < 4; k++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        n_cmp++; if (dbg_state !== ST_RUN || cycles !== 32'd5) begin n_err++; $display("FAIL start_ignored: got st=%0d cycles=%0d required RUN/5", dbg_state, cycles); end
        run_to_end(5, runs);
        n_cmp++; if (cycles !== 32'(exp_runs(12)) || done !== 1'b1) begin n_err++; $display("FAIL start_ignored_end: got cycles=%0d done=%b required %0d/1", cycles, done, exp_runs(12)); end
        n_cmp++; if (ram[3] !== 16'd70) begin n_err++; $display("FAIL start_ignored_res: got %h required %h", ram[3], 16'd70); end
    endtask

    task automatic test_arbitration();
        int runs;
        load_program(10, 1);
        host_write(5, 16'h1111);
        host_write(0, 16'd9);
        host_write(1, 16'd4);
        pulse_start();
        step();
        for (int k = 0; k < 3; k++) step();
        n_cmp++; if (bus.host_gnt !== 1'b0) begin n_err++; $display("FAIL arb_gnt: got %b required 0", bus.host_gnt); end
        host_write(5, 16'h2222);
        n_cmp++; if (ram[5] !== 16'h1111) begin n_err++; $display("FAIL arb_drop: got %h required %h", ram[5], 16'h1111); end
        run_to_end(4, runs);
        n_cmp++; if (runs != exp_runs(22)) begin n_err++; $display("FAIL arb_runs: got %0d required %0d", runs, exp_runs(22)); end
        host_write(5, 16'h2222);
        n_cmp++; if (ram[5] !== 16'h2222) begin n_err++; $display("FAIL arb_land: got %h required %h", ram[5], 16'h2222); end
    endtask

    // END placed so the halt edge is exactly the last allowed RUN edge.
    task automatic test_halt_vs_timeout();
        int runs;
        load_program(MAXC - 13, 0);
        host_write(0, 16'd1);
        host_write(1, 16'd2);
        pulse_start();
        step();
        run_to_end(0, runs);
        n_cmp++; if (done !== 1'b1 || timeout !== 1'b0) begin n_err++; $display("FAIL halt_prio: got done=%b tout=%b required 1/0", done, timeout); end
        n_cmp++; if (cycles !== 32'(MAXC)) begin n_err++; $display("FAIL halt_prio_cycles: got %0d required %0d", cycles, MAXC); end
    endtask

    task automatic test_timeout();
        int runs;
        rom[0] = 16'hEA87;
        pulse_start();
        step();
        n_cmp++; if (bus.cpu_instr !== 16'hEA87) begin n_err++; $display("FAIL tout_instr_run: got %h required ea87", bus.cpu_instr); end
        run_to_end(0, runs);
        n_cmp++; if (runs != MAXC || cycles !== 32'(MAXC)) begin n_err++; $display("FAIL tout_cycles: got runs=%0d cycles=%0d required %0d", runs, cycles, MAXC); end
        n_cmp++; if (timeout !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || dbg_state !== ST_TOUT)
            begin n_err++; $display("FAIL tout_flags: got tout=%b done=%b busy=%b st=%0d required 1/0/0/TOUT", timeout, done, busy, dbg_state); end
        n_cmp++; if (bus.cpu_instr !== 16'h0000 || bus.host_gnt !== 1'b1) begin n_err++; $display("FAIL tout_idle_bus: got instr=%h gnt=%b required 0000/1", bus.cpu_instr, bus.host_gnt); end
    endtask

    // pad 4 puts the M=D store of the sum in RUN cycle 10.
    task automatic test_reset_mid_run();
        int runs;
        load_program(4, 0);
        host_write(2, 16'hDEAD);
        host_write(0, 16'd1000);
        host_write(1, 16'd234);
        pulse_start();
        step();
        for (int k = 0; k < 9; k++) step();
        n_cmp++; if (bus.ram_we !== 1'b1) begin n_err++; $display("FAIL mid_store: got ram_we=%b required 1", bus.ram_we); end
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.ram_we !== 1'b0) begin n_err++; $display("FAIL mid_we_gate: got %b required 0", bus.ram_we); end
        step();
        reset = 1'b0;
        #1;
        n_cmp++; if (dbg_state !== ST_IDLE || busy !== 1'b0 || bus.cpu_reset !== 1'b1 || cycles !== 32'd0)
            begin n_err++; $display("FAIL mid_idle: got st=%0d busy=%b cpu_reset=%b cycles=%0d required IDLE/0/1/0", dbg_state, busy, bus.cpu_reset, cycles); end
        n_cmp++; if (ram[2] !== 16'hDEAD) begin n_err++; $display("FAIL mid_ram_kept: got %h required dead", ram[2]); end
        pulse_start();
        step();
        run_to_end(0, runs);
        n_cmp++; if (cycles !== 32'(exp_runs(10)) || done !== 1'b1) begin n_err++; $display("FAIL mid_rerun: got cycles=%0d done=%b required %0d/1", cycles, done, exp_runs(10)); end
        n_cmp++; if (ram[2] !== 16'd1234) begin n_err++; $display("FAIL mid_rerun_res: got %h required %h", ram[2], 16'd1234); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset          = 1'b1;
        start          = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
        bus.host_we    = 1'b0;
        for (int i = 0; i < 128; i++) rom[i] = 16'hEA87;
        test_reset();
        test_host_access();
        test_program(6);
        test_start_during_run();
        test_arbitration();
        test_halt_vs_timeout();
        test_timeout();
        test_program(2);
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
